// File: rtl/quadrature_generator_pkg.sv
// Shared types and constants for the quadrature step generator.
// Optional build macro: QUADRATURE_EN selects Gray-code quadrature output.
package quadrature_generator_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        PH0,
        PH1,
        PH2,
        PH3
    } gen_state_t;

    // A/B levels for a quadrature phase; up leads with A, down leads with B.
    function automatic logic [1:0] quad_ab(input gen_state_t s, input logic dir);
        logic [1:0] ab;
        case (s)
            PH0:     ab = (dir == DIR_UP) ? 2'b10 : 2'b01;
            PH1:     ab = 2'b11;
            PH2:     ab = (dir == DIR_UP) ? 2'b01 : 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quadrature_generator_if.sv
// Command handshake bundle between a step-command source and the generator.
import quadrature_generator_pkg::*;

interface quadrature_generator_if #(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_done;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready,
        output cmd_done
    );
endinterface

// File: rtl/quadrature_generator_phase_timer.sv
// Phase timer: counts 0..HALF_PERIOD-1 and flags the terminal count.
// Holding restart keeps the count at zero so a new phase starts clean.
module phase_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [TW-1:0] TERM = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] cnt;

    assign tick = (cnt == TERM);

    // Free-running phase counter, wrapping at the terminal count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end
endmodule

// File: rtl/quadrature_generator.sv
// Quadrature step generator: turns (direction, step count) commands into
// timed A/B encoder waveforms and tracks the net emitted position.
// Default build emits one pulse per step (A for up, B for down).
// Defining QUADRATURE_EN emits true Gray-code quadrature instead.
import quadrature_generator_pkg::*;

module quadrature_generator #(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    quadrature_generator_if.slave  cmd,
    output logic                   A,
    output logic                   B,
    output logic                   busy,
    output logic [CNT_W-1:0]       steps_left,
    output logic [CNT_W-1:0]       pos
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    gen_state_t state;
    logic       dir;
    logic       done_r;
    logic       tick;
    logic       accept;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.cmd_done  = done_r;
    assign busy          = (state != IDLE);
    assign accept        = cmd.cmd_valid && (state == IDLE);

    function automatic logic [CNT_W-1:0] step_pos(input logic [CNT_W-1:0] p,
                                                  input logic d);
        return (d == DIR_UP) ? p + ONE : p - ONE;
    endfunction

    // Timer is held at zero while idle and wraps on every phase change.
    phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(state == IDLE),
        .tick   (tick)
    );

    // Command FSM with registered waveform, position and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            dir        <= DIR_UP;
            A          <= 1'b0;
            B          <= 1'b0;
            pos        <= '0;
            steps_left <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd.cmd_steps == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            dir        <= cmd.cmd_dir;
                            steps_left <= cmd.cmd_steps;
                            pos        <= step_pos(pos, cmd.cmd_dir);
`ifdef QUADRATURE_EN
                            state      <= PH0;
                            {A, B}     <= quad_ab(PH0, cmd.cmd_dir);
`else
                            state      <= HIGH;
                            A          <= (cmd.cmd_dir == DIR_UP);
                            B          <= (cmd.cmd_dir == DIR_DOWN);
`endif
                        end
                    end
                end
`ifdef QUADRATURE_EN
                PH0: begin
                    if (tick) begin
                        state  <= PH1;
                        {A, B} <= quad_ab(PH1, dir);
                    end
                end
                PH1: begin
                    if (tick) begin
                        state  <= PH2;
                        {A, B} <= quad_ab(PH2, dir);
                    end
                end
                PH2: begin
                    if (tick) begin
                        state  <= PH3;
                        {A, B} <= quad_ab(PH3, dir);
                    end
                end
                PH3: begin
                    if (tick) begin
                        if (steps_left == ONE) begin
                            steps_left <= '0;
                            state      <= IDLE;
                            done_r     <= 1'b1;
                        end else begin
                            steps_left <= steps_left - ONE;
                            pos        <= step_pos(pos, dir);
                            state      <= PH0;
                            {A, B}     <= quad_ab(PH0, dir);
                        end
                    end
                end
`else
                HIGH: begin
                    if (tick) begin
                        state <= LOW;
                        A     <= 1'b0;
                        B     <= 1'b0;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (steps_left == ONE) begin
                            steps_left <= '0;
                            state      <= IDLE;
                            done_r     <= 1'b1;
                        end else begin
                            steps_left <= steps_left - ONE;
                            pos        <= step_pos(pos, dir);
                            state      <= HIGH;
                            A          <= (dir == DIR_UP);
                            B          <= (dir == DIR_DOWN);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    A     <= 1'b0;
                    B     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_quadrature_generator.sv
// Scoreboard bench for quadrature_generator: commands push expected results,
// a monitor with a loopback decoder checks waveform, timing and position.
module tb_quadrature_generator;
    localparam int HP = 4;
`ifdef QUADRATURE_EN
    localparam int PHASES = 4;
`else
    localparam int PHASES = 2;
`endif

    typedef struct {
        int         n;
        bit         dir;
        logic [7:0] pos;
        int         acc_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       A, B, busy;
    logic [7:0] steps_left, pos;

    quadrature_generator_if #(.CNT_W(8)) cif();

    quadrature_generator #(.HALF_PERIOD(HP), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .steps_left(steps_left),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [7:0] mpos = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Offer a command and hold it until accepted, then log the expectation.
    task automatic issue(input bit d, input int n);
        int guard;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_dir   = d;
        cif.cmd_steps = 8'(n);
        guard = 0;
        while (!cif.cmd_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!cif.cmd_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            cif.cmd_valid = 1'b0;
            return;
        end
        mpos = d ? mpos + 8'(n) : mpos - 8'(n);
        q.push_back('{n: n, dir: d, pos: mpos, acc_cyc: cyc + 1});
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        cif.cmd_dir   = 1'($urandom);
        cif.cmd_steps = 8'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || busy) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: samples just after each rising edge.
    logic [1:0] ab, prev_ab = 2'b00;
    logic [7:0] dec = 8'd0;
    bit         active = 0;
    int         busy_cnt = 0, ra = 0, rb = 0, run_len = 0;
    exp_t       cur, it;

    always @(posedge clk) begin
        #1;
        cyc++;
        ab = {A, B};
        if (!rst) begin
            chk("rst_A", 32'(A), 32'd0);
            chk("rst_B", 32'(B), 32'd0);
            chk("rst_pos", 32'(pos), 32'd0);
            chk("rst_steps_left", 32'(steps_left), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
            chk("rst_done", 32'(cif.cmd_done), 32'd0);
            q.delete();
            active  = 0;
            dec     = 8'd0;
            run_len = 0;
            prev_ab = 2'b00;
        end else begin
            if (prev_ab == 2'b00 && ab == 2'b10) dec = dec + 8'd1;
            else if (prev_ab == 2'b00 && ab == 2'b01) dec = dec - 8'd1;
            if (ab != prev_ab)
                chk("ab_single_change", 32'(ab[1] != prev_ab[1] && ab[0] != prev_ab[0]), 32'd0);
            if (busy && !active) begin
                if (q.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    active = 1;
                    cur = q[0];
                    chk("first_edge_cyc", 32'(cyc), 32'(cur.acc_cyc));
                    chk("steps_left_start", 32'(steps_left), 32'(cur.n));
                    busy_cnt = 0; ra = 0; rb = 0; run_len = 0;
                end
            end
            if (active && busy) begin
                busy_cnt++;
                if (ab != prev_ab) begin
                    if (run_len > 0) chk("phase_len", 32'(run_len), 32'(HP));
                    run_len = 1;
                end else begin
                    run_len++;
                end
                if (!prev_ab[1] && ab[1]) ra++;
                if (!prev_ab[0] && ab[0]) rb++;
            end
            if (cif.cmd_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    it = q.pop_front();
                    if (!active) begin
                        busy_cnt = 0; ra = 0; rb = 0; run_len = 0;
                    end
                    chk("done_latency", 32'(cyc - it.acc_cyc), 32'(PHASES * HP * it.n));
                    chk("busy_cycles", 32'(busy_cnt), 32'(PHASES * HP * it.n));
`ifdef QUADRATURE_EN
                    chk("a_rises", 32'(ra), 32'(it.n));
                    chk("b_rises", 32'(rb), 32'(it.n));
`else
                    chk("a_rises", 32'(ra), it.dir ? 32'(it.n) : 32'd0);
                    chk("b_rises", 32'(rb), it.dir ? 32'd0 : 32'(it.n));
`endif
                    chk("pos", 32'(pos), 32'(it.pos));
                    chk("decoder", 32'(dec), 32'(it.pos));
                    chk("steps_left_end", 32'(steps_left), 32'd0);
                    chk("ab_end", 32'(ab), 32'd0);
                    if (it.n > 0) chk("phase_len_last", 32'(run_len), 32'(HP));
                    active = 0;
                end
            end
            prev_ab = ab;
        end
    end

    initial begin
        int guard;
        cif.cmd_valid = 1'b0;
        cif.cmd_dir   = 1'b0;
        cif.cmd_steps = 8'd0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed sequence from the plan; back-to-back offers test busy gating.
        issue(1'b1, 3);
        issue(1'b0, 2);
        issue(1'b0, 1);
        issue(1'b0, 1);
        issue(1'b1, 1);
        issue(1'b1, 0);
        issue(1'b1, 1);
        wait_idle();

        // Reset during the high phase of step 2 of 5.
        issue(1'b1, 5);
        guard = 0;
        while (!(steps_left == 8'd4 && (A || B)) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_step2", 32'(steps_left), 32'd4);
        rst = 1'b0;
        mpos = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 1);
        wait_idle();
        chk("pos_after_reset_cmd", 32'(pos), 32'd1);

        // Full-width step count wraps the position.
        issue(1'b1, 255);

        // Randomized commands with idle gaps.
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("final_pos", 32'(pos), 32'(mpos));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
